spi_cmd_decoder: RTL
====================

Name: spi_cmd_decoder

Overview:
- Consumes the command/data byte pair assembled by the SPI slave controller and executes one command per SS frame.
- Produces the status byte and MISO response byte the controller shifts out on the next frame.
- Sits between the SPI slave controller and the capture FIFO holding sniffed USB3300 bytes.
- Owns the 8-bit configuration register read by the sniffer core.

Parameters:
- RD_LAT, 1, FIFO read latency in clk cycles from fifo_rd_en to valid fifo_data; legal values 1..3.
- CFG_RST, 8'h00, reset value of cfg_out.

Ports:
- clk  in  1  FPGA reference clock
- rst  in  1  asynchronous active-low reset
- cmd_in  in  8  command byte from SPI slave controller
- data_in  in  8  data byte from SPI slave controller
- frame_valid  in  1  one-cycle pulse: cmd_in/data_in hold a complete frame
- fifo_data  in  8  capture FIFO read data
- fifo_empty  in  1  capture FIFO empty
- fifo_full  in  1  capture FIFO full
- fifo_ovf  in  1  one-cycle pulse: FIFO dropped a byte
- fifo_rd_en  out  1  FIFO pop strobe, one cycle per pop
- sta_out  out  8  status byte to SPI slave controller
- rsp_data  out  8  response byte to SPI slave controller (MISO payload)
- rsp_valid  out  1  one-cycle pulse when rsp_data updated
- cfg_out  out  8  configuration register

Behaviour:
- Reset (rst low, async): state IDLE; fifo_rd_en=0, rsp_data=8'h00, rsp_valid=0, cfg_out=CFG_RST; all sticky flags 0. Outputs take reset values immediately, including mid-pop.
- sta_out is combinational:
  - [0] fifo_empty
  - [1] fifo_full
  - [2] OVF sticky (set by fifo_ovf)
  - [3] UNDERRUN sticky
  - [4] BADCMD sticky
  - [5] COLLISION sticky
  - [6] busy (state != IDLE)
  - [7] 0
- State machine: IDLE, DECODE, RD_ISSUE, RD_WAIT.
  - IDLE: on frame_valid, latch cmd_in/data_in into internal registers -> DECODE.
  - DECODE: execute the latched command (see command list) for one cycle.
  - RD_ISSUE: fifo_rd_en=1 for exactly this cycle; load latency counter with RD_LAT-1 -> RD_WAIT.
  - RD_WAIT: decrement counter; at 0, capture fifo_data into rsp_data, pulse rsp_valid -> IDLE.
- Commands executed in DECODE:
  - 8'h00 NOP: no response update -> IDLE.
  - 8'h01 READ_STATUS: rsp_data<=sta_out, rsp_valid=1 -> IDLE.
  - 8'h02 POP, FIFO not empty: -> RD_ISSUE.
  - 8'h02 POP, FIFO empty: rsp_data<=8'h00, set UNDERRUN, rsp_valid=1 -> IDLE; fifo_rd_en stays 0.
  - 8'h03 WRITE_CFG: cfg_out<=latched data -> IDLE.
  - 8'h04 READ_CFG: rsp_data<=cfg_out, rsp_valid=1 -> IDLE.
  - 8'h05 CLEAR_FLAGS: clear OVF/UNDERRUN/BADCMD/COLLISION -> IDLE.
  - Any other value: set BADCMD -> IDLE.
- Latencies from the frame_valid cycle T:
  - READ_CFG/READ_STATUS: rsp_valid at T+1, rsp_data valid T+2.
  - POP: fifo_rd_en at T+2; rsp_valid at T+2+RD_LAT.
- frame_valid while state != IDLE: frame dropped, COLLISION set, the in-progress command is unaffected.
- Simultaneous flag set (fifo_ovf, collision) and CLEAR_FLAGS in the same cycle: set wins.
- fifo_ovf in any state sets OVF.

Optional Feature:
- Macro SPI_CMD_FRAME_CNT_EN.
- Defined:
  - 8-bit frame counter increments on every accepted frame (including NOP and bad commands, excluding collisions); wraps 8'hFF->8'h00; reset 0.
  - Command 8'h06 READ_FRAME_CNT: rsp_data<=counter value after the increment for this frame, rsp_valid=1.
- Undefined: no counter logic; 8'h06 sets BADCMD.

Test Plan:
- Reset with cfg_out and rsp_data ≠ 0, rst low -> cfg_out=CFG_RST, rsp_data=00, sta_out=8'h01 when fifo_empty=1.
- WRITE_CFG data 8'hA5, then READ_CFG -> cfg_out=A5 at T+2; rsp_data=A5, rsp_valid one pulse at T+1.
- POP with FIFO non-empty (fifo_data=8'h3C), RD_LAT=1 and 3 -> single fifo_rd_en at T+2, rsp_data=3C, rsp_valid at T+3 / T+5. POP with FIFO empty -> no rd_en, rsp_data=00, sta_out[3]=1.
- cmd 8'h7F -> sta_out[4]=1; fifo_ovf pulse in same cycle as CLEAR_FLAGS DECODE -> sta_out[2]=1 after, [4]=0.
- Second frame_valid at T+1 during POP -> sta_out[5]=1, only one fifo_rd_en, first POP completes.
- rst low during RD_WAIT -> fifo_rd_en=0, state IDLE, busy=0. With SPI_CMD_FRAME_CNT_EN, 256 NOPs then READ_FRAME_CNT -> rsp_data=8'h01.

Source files
------------

// File: rtl/spi_cmd_decoder.sv
// rtl/spi_cmd_decoder.sv - SPI command decoder between SPI slave controller and capture FIFO
//
// Executes one command per SS frame, serves FIFO pops, and owns the
// configuration register read by the sniffer core.
//
// Parameters:
//   RD_LAT   FIFO read latency in clk cycles (1..3)
//   CFG_RST  reset value of cfg_out
//
// Optional build macro: SPI_CMD_FRAME_CNT_EN adds an 8-bit accepted-frame
// counter and the READ_FRAME_CNT (8'h06) command.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   cmd_in        command byte of the current frame
//   data_in       data byte of the current frame
//   frame_valid   one-cycle pulse, cmd_in/data_in complete
//   fifo_data     capture FIFO read data
//   fifo_empty    capture FIFO empty
//   fifo_full     capture FIFO full
//   fifo_ovf      one-cycle pulse, FIFO dropped a byte
//   fifo_rd_en    FIFO pop strobe
//   sta_out       status byte {0, busy, coll, badcmd, underrun, ovf, full, empty}
//   rsp_data      MISO response byte
//   rsp_valid     pulse in the cycle whose closing edge loads rsp_data
//   cfg_out       configuration register
module spi_cmd_decoder #(
  parameter int unsigned RD_LAT  = 1,
  parameter logic [7:0]  CFG_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_in,
  input  logic [7:0] data_in,
  input  logic       frame_valid,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic       fifo_ovf,
  output logic       fifo_rd_en,
  output logic [7:0] sta_out,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  output logic [7:0] cfg_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    RD_ISSUE = 2'd2,
    RD_WAIT  = 2'd3
  } state_e;

  localparam logic [7:0] CMD_NOP         = 8'h00;
  localparam logic [7:0] CMD_READ_STATUS = 8'h01;
  localparam logic [7:0] CMD_POP         = 8'h02;
  localparam logic [7:0] CMD_WRITE_CFG   = 8'h03;
  localparam logic [7:0] CMD_READ_CFG    = 8'h04;
  localparam logic [7:0] CMD_CLEAR_FLAGS = 8'h05;
`ifdef SPI_CMD_FRAME_CNT_EN
  localparam logic [7:0] CMD_READ_FCNT   = 8'h06;
`endif

  // Counter load value: RD_WAIT lasts RD_LAT cycles, capturing on the last.
  localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] dat_q, dat_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] cfg_q, cfg_d;
  logic       ovf_q, ovf_d;
  logic       und_q, und_d;
  logic       bad_q, bad_d;
  logic       col_q, col_d;
`ifdef SPI_CMD_FRAME_CNT_EN
  logic [7:0] fcnt_q, fcnt_d;
`endif

  assign sta_out    = {1'b0, (state_q != IDLE), col_q, bad_q, und_q, ovf_q,
                       fifo_full, fifo_empty};
  assign fifo_rd_en = (state_q == RD_ISSUE);
  assign rsp_data   = rsp_data_q;
  assign cfg_out    = cfg_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    cfg_d      = cfg_q;
    ovf_d      = ovf_q;
    und_d      = und_q;
    bad_d      = bad_q;
    col_d      = col_q;
    rsp_valid  = 1'b0;
`ifdef SPI_CMD_FRAME_CNT_EN
    fcnt_d     = fcnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          cmd_d   = cmd_in;
          dat_d   = data_in;
          state_d = DECODE;
`ifdef SPI_CMD_FRAME_CNT_EN
          fcnt_d  = fcnt_q + 8'd1;
`endif
        end
      end

      DECODE: begin
        state_d = IDLE;
        case (cmd_q)
          CMD_NOP: ;
          CMD_READ_STATUS: begin
            rsp_data_d = sta_out;
            rsp_valid  = 1'b1;
          end
          CMD_POP: begin
            if (!fifo_empty) begin
              state_d = RD_ISSUE;
            end else begin
              rsp_data_d = 8'h00;
              und_d      = 1'b1;
              rsp_valid  = 1'b1;
            end
          end
          CMD_WRITE_CFG: cfg_d = dat_q;
          CMD_READ_CFG: begin
            rsp_data_d = cfg_q;
            rsp_valid  = 1'b1;
          end
          CMD_CLEAR_FLAGS: begin
            ovf_d = 1'b0;
            und_d = 1'b0;
            bad_d = 1'b0;
            col_d = 1'b0;
          end
`ifdef SPI_CMD_FRAME_CNT_EN
          // Counter already holds the value including this frame.
          CMD_READ_FCNT: begin
            rsp_data_d = fcnt_q;
            rsp_valid  = 1'b1;
          end
`endif
          default: bad_d = 1'b1;
        endcase
      end

      RD_ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (cnt_q == 2'd0) begin
          rsp_data_d = fifo_data;
          rsp_valid  = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Flag sets are applied last so they win over a same-cycle CLEAR_FLAGS.
    if (fifo_ovf) begin
      ovf_d = 1'b1;
    end
    if (frame_valid && (state_q != IDLE)) begin
      col_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      dat_q      <= 8'h00;
      cnt_q      <= 2'd0;
      rsp_data_q <= 8'h00;
      cfg_q      <= CFG_RST;
      ovf_q      <= 1'b0;
      und_q      <= 1'b0;
      bad_q      <= 1'b0;
      col_q      <= 1'b0;
`ifdef SPI_CMD_FRAME_CNT_EN
      fcnt_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      cfg_q      <= cfg_d;
      ovf_q      <= ovf_d;
      und_q      <= und_d;
      bad_q      <= bad_d;
      col_q      <= col_d;
`ifdef SPI_CMD_FRAME_CNT_EN
      fcnt_q     <= fcnt_d;
`endif
    end
  end

endmodule
